// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS control FSM with memory handshake, timeout and sticky error
//
// Purpose: sequences fetch/decode/execute/memory/writeback for each instruction
// and drives every datapath mux select and write enable from the current state.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   op        in   opcode field of the instruction register
//   memready  in   memory completes the current access
//   iord, irwrite, memread, memwrite, branch, brinv, pcwrite, regwrite,
//   alusrca, extzero                      out  single-bit datapath controls
//   memtoreg  out  00 ALUOut, 01 data reg, 10 PC
//   regdst    out  00 rt, 01 rd, 10 $31
//   alusrcb   out  00 B, 01 const 4, 10 imm, 11 imm<<2
//   aluop     out  000 add, 001 sub, 010 funct, 011 and, 100 or
//   pcsrc     out  00 ALU, 01 ALUOut, 10 jump target
//   retire    out  one-cycle pulse on the last cycle of an instruction
//   err       out  00 none, 01 illegal opcode, 10 memory timeout (sticky)
//   state_o   out  current state, for debug
module multicycle_ctrl #(
  parameter int              OP_W          = 6,
  parameter logic [OP_W-1:0] OP_RTYPE      = 'h00,
  parameter logic [OP_W-1:0] OP_LW         = 'h23,
  parameter logic [OP_W-1:0] OP_SW         = 'h2B,
  parameter logic [OP_W-1:0] OP_BEQ        = 'h04,
  parameter logic [OP_W-1:0] OP_BNE        = 'h05,
  parameter logic [OP_W-1:0] OP_ADDI       = 'h08,
  parameter logic [OP_W-1:0] OP_ANDI       = 'h0C,
  parameter logic [OP_W-1:0] OP_ORI        = 'h0D,
  parameter logic [OP_W-1:0] OP_J          = 'h02,
  parameter logic [OP_W-1:0] OP_JAL        = 'h03,
  parameter bit              MEM_HANDSHAKE = 1'b1,
  parameter int              MEM_TIMEOUT   = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] op,
  input  logic            memready,
  output logic            iord,
  output logic            irwrite,
  output logic            memread,
  output logic            memwrite,
  output logic            branch,
  output logic            brinv,
  output logic            pcwrite,
  output logic            regwrite,
  output logic            alusrca,
  output logic            extzero,
  output logic [1:0]      memtoreg,
  output logic [1:0]      regdst,
  output logic [1:0]      alusrcb,
  output logic [2:0]      aluop,
  output logic [1:0]      pcsrc,
  output logic            retire,
  output logic [1:0]      err,
  output logic [4:0]      state_o
);

  typedef enum logic [4:0] {
    S_FETCH  = 5'd0,
    S_DECODE = 5'd1,
    S_MEMADR = 5'd2,
    S_MEMRD  = 5'd3,
    S_MEMWB  = 5'd4,
    S_MEMWR  = 5'd5,
    S_RTEX   = 5'd6,
    S_RTWB   = 5'd7,
    S_BEQ    = 5'd8,
    S_BNE    = 5'd9,
    S_ADDIEX = 5'd10,
    S_ANDIEX = 5'd11,
    S_ORIEX  = 5'd12,
    S_IWB    = 5'd13,
    S_JUMP   = 5'd14,
    S_JAL    = 5'd15,
    S_ERROR  = 5'd16
  } state_t;

  // Width kept at least 1 so a disabled timeout still yields a legal vector.
  localparam int CNT_W  = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam bit TMO_EN = MEM_HANDSHAKE && (MEM_TIMEOUT > 0);
  // The counter holds the number of wait cycles already spent; the wait cycle
  // that would bring it to MEM_TIMEOUT is the one that trips the timeout.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       err_q, err_d;
  logic             mem_rdy;
  logic             mem_wait;
  logic             tmo_hit;

  // Without the handshake, memory is assumed to finish every access at once.
  assign mem_rdy  = MEM_HANDSHAKE ? memready : 1'b1;
  assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR)) && !mem_rdy;
  // memready high on the limit cycle completes the access, so no timeout then.
  assign tmo_hit  = TMO_EN && mem_wait && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      S_FETCH:  if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        if (op == OP_RTYPE)                     state_d = S_RTEX;
        else if ((op == OP_LW) || (op == OP_SW)) state_d = S_MEMADR;
        else if (op == OP_BEQ)                  state_d = S_BEQ;
        else if (op == OP_BNE)                  state_d = S_BNE;
        else if (op == OP_ADDI)                 state_d = S_ADDIEX;
        else if (op == OP_ANDI)                 state_d = S_ANDIEX;
        else if (op == OP_ORI)                  state_d = S_ORIEX;
        else if (op == OP_J)                    state_d = S_JUMP;
        else if (op == OP_JAL)                  state_d = S_JAL;
        else begin
          state_d = S_ERROR;
          err_d   = 2'b01;
        end
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_rdy) state_d = S_MEMWB;
      S_MEMWR:  if (mem_rdy) state_d = S_FETCH;
      S_RTEX:   state_d = S_RTWB;
      S_ADDIEX, S_ANDIEX, S_ORIEX: state_d = S_IWB;
      S_MEMWB, S_RTWB, S_BEQ, S_BNE, S_IWB, S_JUMP, S_JAL: state_d = S_FETCH;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_FETCH;
    endcase
    if (tmo_hit) begin
      state_d = S_ERROR;
      err_d   = 2'b10;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = '0;
    else if (TMO_EN && mem_wait) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    iord     = 1'b0;
    irwrite  = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    branch   = 1'b0;
    brinv    = 1'b0;
    pcwrite  = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    extzero  = 1'b0;
    memtoreg = 2'b00;
    regdst   = 2'b00;
    alusrcb  = 2'b00;
    aluop    = 3'b000;
    pcsrc    = 2'b00;
    retire   = 1'b0;
    case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_rdy;
        pcwrite = mem_rdy;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        memread = 1'b1;
      end
      S_MEMWB: begin
        memtoreg = 2'b01;
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        retire   = mem_rdy;
      end
      S_RTEX: begin
        alusrca = 1'b1;
        aluop   = 3'b010;
      end
      S_RTWB: begin
        regdst   = 2'b01;
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      S_BEQ, S_BNE: begin
        alusrca = 1'b1;
        aluop   = 3'b001;
        branch  = 1'b1;
        pcsrc   = 2'b01;
        retire  = 1'b1;
        brinv   = (state_q == S_BNE);
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = 3'b000;
      end
      S_ANDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = 3'b011;
        extzero = 1'b1;
      end
      S_ORIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = 3'b100;
        extzero = 1'b1;
      end
      S_IWB: begin
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        retire  = 1'b1;
      end
      S_JAL: begin
        // PC was already advanced in FETCH, so the link value is PC+4.
        pcsrc    = 2'b10;
        pcwrite  = 1'b1;
        regwrite = 1'b1;
        regdst   = 2'b10;
        memtoreg = 2'b10;
        retire   = 1'b1;
      end
      default: ;
    endcase
  end

  assign err     = err_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl against an instruction-path model
module tb_multicycle_ctrl;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'h00;
  logic       memready = 1'b0;
  logic       iord, irwrite, memread, memwrite, branch, brinv, pcwrite, regwrite, alusrca, extzero;
  logic [1:0] memtoreg, regdst, alusrcb, pcsrc, err;
  logic [2:0] aluop;
  logic       retire;
  logic [4:0] state_o;
  logic [21:0] dut_ctrl;

  multicycle_ctrl #(.MEM_HANDSHAKE(1'b1), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .op(op), .memready(memready),
    .iord(iord), .irwrite(irwrite), .memread(memread), .memwrite(memwrite),
    .branch(branch), .brinv(brinv), .pcwrite(pcwrite), .regwrite(regwrite),
    .alusrca(alusrca), .extzero(extzero), .memtoreg(memtoreg), .regdst(regdst),
    .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc), .retire(retire),
    .err(err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  assign dut_ctrl = {iord, irwrite, memread, memwrite, branch, brinv, pcwrite, regwrite,
                     alusrca, extzero, memtoreg, regdst, alusrcb, aluop, pcsrc, retire};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Expected control word per state, straight from the state/output table.
  function automatic logic [21:0] exp_ctrl(input int s, input logic mr);
    logic       e_iord = 0, e_irw = 0, e_mrd = 0, e_mwr = 0, e_br = 0, e_inv = 0;
    logic       e_pcw = 0, e_rw = 0, e_sa = 0, e_ez = 0, e_ret = 0;
    logic [1:0] e_m2r = 0, e_rd = 0, e_sb = 0, e_pcs = 0;
    logic [2:0] e_alu = 0;
    case (s)
      0:  begin e_mrd = 1; e_sb = 2'b01; e_irw = mr; e_pcw = mr; end
      1:  e_sb = 2'b11;
      2:  begin e_sa = 1; e_sb = 2'b10; end
      3:  begin e_iord = 1; e_mrd = 1; end
      4:  begin e_m2r = 2'b01; e_rw = 1; e_ret = 1; end
      5:  begin e_iord = 1; e_mwr = 1; e_ret = mr; end
      6:  begin e_sa = 1; e_alu = 3'b010; end
      7:  begin e_rd = 2'b01; e_rw = 1; e_ret = 1; end
      8:  begin e_sa = 1; e_alu = 3'b001; e_br = 1; e_pcs = 2'b01; e_ret = 1; end
      9:  begin e_sa = 1; e_alu = 3'b001; e_br = 1; e_inv = 1; e_pcs = 2'b01; e_ret = 1; end
      10: begin e_sa = 1; e_sb = 2'b10; end
      11: begin e_sa = 1; e_sb = 2'b10; e_alu = 3'b011; e_ez = 1; end
      12: begin e_sa = 1; e_sb = 2'b10; e_alu = 3'b100; e_ez = 1; end
      13: begin e_rw = 1; e_ret = 1; end
      14: begin e_pcs = 2'b10; e_pcw = 1; e_ret = 1; end
      15: begin e_pcs = 2'b10; e_pcw = 1; e_rw = 1; e_rd = 2'b10; e_m2r = 2'b10; e_ret = 1; end
      default: ;
    endcase
    return {e_iord, e_irw, e_mrd, e_mwr, e_br, e_inv, e_pcw, e_rw, e_sa, e_ez,
            e_m2r, e_rd, e_sb, e_alu, e_pcs, e_ret};
  endfunction

  typedef int iq_t[$];

  // States an instruction visits after DECODE; empty means illegal opcode.
  function automatic iq_t route(input logic [5:0] o);
    iq_t q;
    case (o)
      6'h00: begin q.push_back(6); q.push_back(7); end
      6'h23: begin q.push_back(2); q.push_back(3); q.push_back(4); end
      6'h2B: begin q.push_back(2); q.push_back(5); end
      6'h04: q.push_back(8);
      6'h05: q.push_back(9);
      6'h08: begin q.push_back(10); q.push_back(13); end
      6'h0C: begin q.push_back(11); q.push_back(13); end
      6'h0D: begin q.push_back(12); q.push_back(13); end
      6'h02: q.push_back(14);
      6'h03: q.push_back(15);
      default: ;
    endcase
    return q;
  endfunction

  int  m_state = 0;
  int  m_err = 0;
  int  m_waits = 0;
  int  m_err_cycles = 0;
  int  m_retired = 0;
  int  dut_retires = 0;
  iq_t m_path;

  // Called in the low clock phase; leaves the bench just after the next falling edge.
  task automatic step(input logic [5:0] op_v, input logic mr_v);
    op = op_v;
    memready = mr_v;
    #1;
    chk("state", 32'(state_o), 32'(m_state));
    chk("err", 32'(err), 32'(m_err));
    chk($sformatf("ctrl_s%0d", m_state), 32'(dut_ctrl), 32'(exp_ctrl(m_state, mr_v)));
    if (retire) dut_retires++;
    if (m_state == 16) begin
      m_err_cycles++;
    end else if ((m_state == 0 || m_state == 3 || m_state == 5) && !mr_v) begin
      m_waits++;
      if (m_waits == TMO) begin
        m_state = 16;
        m_err = 2;
        m_waits = 0;
      end
    end else begin
      m_waits = 0;
      if (m_state == 0) begin
        m_state = 1;
      end else if (m_state == 1) begin
        m_path = route(op_v);
        if (m_path.size() == 0) begin
          m_state = 16;
          m_err = 1;
        end else begin
          m_state = m_path.pop_front();
        end
      end else if (m_path.size() == 0) begin
        m_state = 0;
        m_retired++;
      end else begin
        m_state = m_path.pop_front();
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ctrl", 32'(dut_ctrl), 32'(exp_ctrl(0, memready)));
    reset = 1'b0;
    #1;
    m_state = 0;
    m_err = 0;
    m_waits = 0;
    m_err_cycles = 0;
    m_path.delete();
  endtask

  logic [5:0] legal [10] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h02, 6'h03};
  logic [5:0] cur_op;

  initial begin
    @(negedge clk);
    do_reset();

    // R-type, memready tied high
    repeat (4) step(6'h00, 1'b1);
    chk("rtype_retires", 32'(dut_retires), 32'd1);

    // LW with three memory wait cycles in MEMRD
    repeat (3) step(6'h23, 1'b1);
    repeat (3) step(6'h23, 1'b0);
    repeat (2) step(6'h23, 1'b1);
    chk("lw_retires", 32'(dut_retires), 32'd2);

    // BNE and JAL
    repeat (3) step(6'h05, 1'b1);
    repeat (3) step(6'h03, 1'b1);
    chk("br_jal_retires", 32'(dut_retires), 32'd4);

    // Illegal opcode: ERROR holds for 20 cycles whatever the inputs
    repeat (2) step(6'h3F, 1'b1);
    for (int i = 0; i < 20; i++) step(6'($urandom), 1'($urandom));
    chk("illegal_err", 32'(err), 32'd1);
    do_reset();

    // Fetch timeout after four wait cycles
    repeat (4) step(6'h00, 1'b0);
    step(6'h00, 1'b1);
    chk("tmo_err", 32'(err), 32'd2);
    do_reset();

    // memready arriving on the limit cycle completes the fetch
    repeat (3) step(6'h00, 1'b0);
    step(6'h00, 1'b1);
    chk("tmo_edge_state", 32'(state_o), 32'd1);
    repeat (3) step(6'h00, 1'b1);

    // Randomized traffic with occasional mid-instruction resets
    cur_op = 6'h00;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (m_state == 16 && m_err_cycles >= 20) do_reset();
      else if ($urandom_range(0, 99) == 0) do_reset();
      if (m_state == 0 || m_state == 16) begin
        if ($urandom_range(0, 9) == 0) cur_op = 6'($urandom);
        else cur_op = legal[$urandom_range(0, 9)];
      end
      step(cur_op, $urandom_range(0, 9) < 6);
    end

    chk("retire_count", 32'(dut_retires), 32'(m_retired));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
